// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Control latched at start; neg_res covers product sign and quotient sign.
  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
  } ctrl_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return int'($clog2(w)) + 1;
  endfunction

endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// Conditional two's-complement negate, parameterised width.
module sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  always_comb begin
    val_o = neg_i ? ('0 - val_i) : val_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit owning the HI/LO registers; one result bit per cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic             is_div, is_signed, sa, sb, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_div    = (op == OP_DIVU) || (op == OP_DIV);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sa        = is_signed & a[WIDTH-1];
  assign sb        = is_signed & b[WIDTH-1];
  assign b_zero    = (b == '0);

  sign_fix #(.W(WIDTH)) u_mag_a (.val_i(a), .neg_i(sa), .val_o(mag_a));
  sign_fix #(.W(WIDTH)) u_mag_b (.val_i(b), .neg_i(sb), .val_o(mag_b));

  // Multiply: acc = {partial, multiplier}; add into upper half, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] step_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign step_next = ctrl_q.is_div ? div_next : mul_next;

  sign_fix #(.W(2*WIDTH)) u_prod (.val_i(step_next), .neg_i(ctrl_q.neg_res), .val_o(prod_fix));
  sign_fix #(.W(WIDTH)) u_quo (.val_i(step_next[WIDTH-1:0]), .neg_i(ctrl_q.neg_res),
                               .val_o(quo_fix));
  sign_fix #(.W(WIDTH)) u_rem (.val_i(step_next[2*WIDTH-1:WIDTH]), .neg_i(ctrl_q.neg_rem),
                               .val_o(rem_fix));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ctrl_d  = ctrl_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wd;
        if (lo_we) lo_d = wd;
        if (start) begin
          state_d        = ST_RUN;
          count_d        = '0;
          ctrl_d.is_div  = is_div;
          // Divide-by-zero keeps the all-ones quotient unnegated.
          ctrl_d.neg_res = (sa ^ sb) & ~(is_div & b_zero);
          ctrl_d.neg_rem = sa;
          opnd_d         = is_div ? mag_b : mag_a;
          acc_d          = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        end
      end
      default: begin
        acc_d   = step_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (ctrl_q.is_div) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ctrl_q  <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wd = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int errors  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    int cyc = 0;
    int dn  = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv;
    while (busy && cyc < 100) begin
      cyc++;
      if (done) dn++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 64'(cyc), 64'd32);
    chk({tag, " early done"}, 64'(dn), 64'd0);
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, el});
    @(negedge clk);
    chk({tag, " done one cycle"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int cyc;
    int dn;
    repeat (2) @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    rst = 1'b1;

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max");
    run_op(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult -3*7");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    run_op(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu 100/7");
    run_op(OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, "divu by 0");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "div ovf");

    // Hazards: start held high throughout the run, mthi pulse at cycle 5.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'h12345678; b = 32'd9;
    @(negedge clk);
    op = OP_DIVU; a = 32'd50; b = 32'd3;
    cyc = 0; dn = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (done) dn++;
      hi_we = (cyc == 5);
      wd    = 32'hDEAD;
      @(negedge clk);
      if (cyc == 5) chk("hazard mthi ignored", {32'd0, hi}, 64'd0);
    end
    start = 1'b0; hi_we = 1'b0;
    chk("hazard busy cycles", 64'(cyc), 64'd32);
    chk("hazard early done", 64'(dn), 64'd0);
    chk("hazard done", {63'd0, done}, 64'd1);
    chk("hazard hi", {32'd0, hi}, 64'd0);
    chk("hazard lo", {32'd0, lo}, 64'h00000000A3D70A38);
    @(negedge clk);
    chk("hazard no restart", {63'd0, busy}, 64'd0);

    lo_we = 1'b1; wd = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo lo", {32'd0, lo}, 64'h55);
    chk("mtlo hi kept", {32'd0, hi}, 64'd0);

    // Reset in the middle of a divide.
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre-reset busy", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #1;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort lo", {32'd0, lo}, 64'd0);
    chk("abort hi", {32'd0, hi}, 64'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort no done", 64'(dn), 64'd0);

    run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu 6*7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
